// File: rtl/instruction_decoder.sv
// ============================================================================
// Module  : instruction_decoder
// Purpose : Instruction register, opcode/step decode, datapath enables,
//           carry/zero flags and sticky halt. Optional illegal-opcode trap
//           enabled by defining ILLEGAL_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_decoder #(
    parameter int OPW = 4,
    parameter int ADW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPW+ADW-1:0]   bus_in,
    input  logic                 in_bus,
    input  logic                 fetch_complete,
    input  logic [1:0]           step,
    input  logic                 alu_carry,
    input  logic                 alu_zero,
    output logic [1:0]           steps_required,
    output logic                 mar_controller,
    output logic                 ram_controller_read,
    output logic                 ir_out_en,
    output logic                 a_load,
    output logic                 b_load,
    output logic                 alu_sub,
    output logic                 alu_out_en,
    output logic                 a_out_en,
    output logic                 ram_write,
    output logic                 out_load,
    output logic                 pc_load,
    output logic                 halted,
    output logic                 illegal_op,
    output logic [OPW+ADW-1:0]   ir_q
);

    localparam int c_irw = OPW + ADW;

    localparam logic [OPW-1:0] c_op_nop = OPW'(4'h0);
    localparam logic [OPW-1:0] c_op_lda = OPW'(4'h1);
    localparam logic [OPW-1:0] c_op_add = OPW'(4'h2);
    localparam logic [OPW-1:0] c_op_sub = OPW'(4'h3);
    localparam logic [OPW-1:0] c_op_sta = OPW'(4'h4);
    localparam logic [OPW-1:0] c_op_ldi = OPW'(4'h5);
    localparam logic [OPW-1:0] c_op_jmp = OPW'(4'h6);
    localparam logic [OPW-1:0] c_op_jc  = OPW'(4'h7);
    localparam logic [OPW-1:0] c_op_jz  = OPW'(4'h8);
    localparam logic [OPW-1:0] c_op_out = OPW'(4'hE);
    localparam logic [OPW-1:0] c_op_hlt = OPW'(4'hF);

    logic [c_irw-1:0] r_ir;
    logic             r_carry;
    logic             r_zero;
    logic             r_halted;
    logic [OPW-1:0]   w_opcode;
    logic             w_exec;
    logic             w_s0;
    logic             w_flag_upd;
    logic             w_illegal;

    assign w_opcode   = r_ir[c_irw-1 -: OPW];
    assign w_exec     = fetch_complete && !r_halted;
    assign w_s0       = w_exec && (step == 2'd0);
    assign w_flag_upd = w_exec && (step == 2'd3) &&
                        ((w_opcode == c_op_add) || (w_opcode == c_op_sub));

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    assign w_illegal = (w_opcode >= OPW'(4'h9)) && (w_opcode <= OPW'(4'hD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_illegal <= 1'b0;
        end else if (w_s0 && w_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_op = r_illegal;
`else
    assign w_illegal  = 1'b0;
    assign illegal_op = 1'b0;
`endif

    // IR only loads during fetch; a strobe seen in execute or after halt is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir     <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            if (in_bus && !fetch_complete && !r_halted) begin
                r_ir <= bus_in;
            end
            if (w_flag_upd) begin
                r_carry <= alu_carry;
                r_zero  <= alu_zero;
            end
            if (w_s0 && ((w_opcode == c_op_hlt) || w_illegal)) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Step count depends only on the opcode so the controller sees it before step 0.
    always_comb begin
        steps_required = 2'd0;
        case (w_opcode)
            c_op_lda, c_op_sta: steps_required = 2'd2;
            c_op_add, c_op_sub: steps_required = 2'd3;
            default:            steps_required = 2'd0;
        endcase
    end

    always_comb begin
        mar_controller      = 1'b0;
        ram_controller_read = 1'b0;
        ir_out_en           = 1'b0;
        a_load              = 1'b0;
        b_load              = 1'b0;
        alu_sub             = 1'b0;
        alu_out_en          = 1'b0;
        a_out_en            = 1'b0;
        ram_write           = 1'b0;
        out_load            = 1'b0;
        pc_load             = 1'b0;
        if (w_exec) begin
            case (w_opcode)
                c_op_lda: begin
                    case (step)
                        2'd0: mar_controller = 1'b1;
                        2'd1: begin
                            ir_out_en           = 1'b1;
                            ram_controller_read = 1'b1;
                        end
                        2'd2: a_load = 1'b1;
                        default: ;
                    endcase
                end
                c_op_add, c_op_sub: begin
                    case (step)
                        2'd0: mar_controller = 1'b1;
                        2'd1: begin
                            ir_out_en           = 1'b1;
                            ram_controller_read = 1'b1;
                        end
                        2'd2: b_load = 1'b1;
                        default: begin
                            alu_out_en = 1'b1;
                            a_load     = 1'b1;
                            alu_sub    = (w_opcode == c_op_sub);
                        end
                    endcase
                end
                c_op_sta: begin
                    case (step)
                        2'd0: mar_controller = 1'b1;
                        2'd1: ir_out_en = 1'b1;
                        2'd2: begin
                            a_out_en  = 1'b1;
                            ram_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                c_op_ldi: begin
                    ir_out_en = (step == 2'd0);
                    a_load    = (step == 2'd0);
                end
                c_op_jmp: begin
                    ir_out_en = (step == 2'd0);
                    pc_load   = (step == 2'd0);
                end
                c_op_jc: begin
                    ir_out_en = (step == 2'd0);
                    pc_load   = (step == 2'd0) && r_carry;
                end
                c_op_jz: begin
                    ir_out_en = (step == 2'd0);
                    pc_load   = (step == 2'd0) && r_zero;
                end
                c_op_out: begin
                    a_out_en = (step == 2'd0);
                    out_load = (step == 2'd0);
                end
                c_op_nop: ;
                default: ;
            endcase
        end
    end

    assign halted = r_halted;
    assign ir_q   = r_ir;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decoder.sv
// ============================================================================
// Module  : tb_instruction_decoder
// Purpose : Directed self-checking bench for instruction_decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] bus_in;
    logic       in_bus;
    logic       fetch_complete;
    logic [1:0] step;
    logic       alu_carry;
    logic       alu_zero;
    logic [1:0] steps_required;
    logic       mar_controller, ram_controller_read, ir_out_en, a_load, b_load;
    logic       alu_sub, alu_out_en, a_out_en, ram_write, out_load, pc_load;
    logic       halted, illegal_op;
    logic [7:0] ir_q;

    int n_vec = 0;
    int n_err = 0;

    // Enable vector bit positions
    localparam logic [10:0] c_mar = 11'h400;
    localparam logic [10:0] c_rd  = 11'h200;
    localparam logic [10:0] c_iro = 11'h100;
    localparam logic [10:0] c_al  = 11'h080;
    localparam logic [10:0] c_bl  = 11'h040;
    localparam logic [10:0] c_sub = 11'h020;
    localparam logic [10:0] c_alo = 11'h010;
    localparam logic [10:0] c_ao  = 11'h008;
    localparam logic [10:0] c_rw  = 11'h004;
    localparam logic [10:0] c_ol  = 11'h002;
    localparam logic [10:0] c_pc  = 11'h001;

    logic [10:0] w_en;
    assign w_en = {mar_controller, ram_controller_read, ir_out_en, a_load, b_load,
                   alu_sub, alu_out_en, a_out_en, ram_write, out_load, pc_load};

    instruction_decoder #(.OPW(4), .ADW(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus_in              (bus_in),
        .in_bus              (in_bus),
        .fetch_complete      (fetch_complete),
        .step                (step),
        .alu_carry           (alu_carry),
        .alu_zero            (alu_zero),
        .steps_required      (steps_required),
        .mar_controller      (mar_controller),
        .ram_controller_read (ram_controller_read),
        .ir_out_en           (ir_out_en),
        .a_load              (a_load),
        .b_load              (b_load),
        .alu_sub             (alu_sub),
        .alu_out_en          (alu_out_en),
        .a_out_en            (a_out_en),
        .ram_write           (ram_write),
        .out_load            (out_load),
        .pc_load             (pc_load),
        .halted              (halted),
        .illegal_op          (illegal_op),
        .ir_q                (ir_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [7:0] b);
        fetch_complete = 1'b0;
        in_bus         = 1'b1;
        bus_in         = b;
        tick();
        in_bus         = 1'b0;
        bus_in         = 8'h00;
    endtask

    // Apply an execute step, check decode, then advance through the edge.
    task automatic exec_check(input string tag, input logic [1:0] s,
                              input logic [10:0] exp_en, input logic [1:0] exp_sr);
        fetch_complete = 1'b1;
        step           = s;
        #1;
        check({tag, "_en"}, 32'(w_en), 32'(exp_en));
        check({tag, "_sr"}, 32'(steps_required), 32'(exp_sr));
        tick();
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        fetch_complete = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; bus_in = 8'h00; in_bus = 1'b0; fetch_complete = 1'b0;
        step = 2'd0; alu_carry = 1'b0; alu_zero = 1'b0;
        tick();
        check("rst_ir", 32'(ir_q), 32'h00);
        check("rst_en", 32'(w_en), 32'h0);
        check("rst_halt", 32'({halted, illegal_op}), 32'h0);
        check("rst_sr", 32'(steps_required), 32'h0);
        rst = 1'b1;
        tick();

        // LDA 1A
        load_ir(8'h1A);
        check("lda_ir", 32'(ir_q), 32'h1A);
        check("lda_sr_pre", 32'(steps_required), 32'd2);
        exec_check("lda_s0", 2'd0, c_mar, 2'd2);
        exec_check("lda_s1", 2'd1, c_iro | c_rd, 2'd2);
        exec_check("lda_s2", 2'd2, c_al, 2'd2);
        exec_check("lda_s3", 2'd3, 11'h0, 2'd2);

        // ADD sets carry=1, zero=0
        load_ir(8'h23);
        exec_check("add_s0", 2'd0, c_mar, 2'd3);
        exec_check("add_s1", 2'd1, c_iro | c_rd, 2'd3);
        exec_check("add_s2", 2'd2, c_bl, 2'd3);
        alu_carry = 1'b1; alu_zero = 1'b0;
        exec_check("add_s3", 2'd3, c_alo | c_al, 2'd3);
        alu_carry = 1'b0;
        load_ir(8'h75);
        exec_check("jc_c1", 2'd0, c_iro | c_pc, 2'd0);
        load_ir(8'h85);
        exec_check("jz_z0", 2'd0, c_iro, 2'd0);

        // in_bus during execute is ignored
        fetch_complete = 1'b1; in_bus = 1'b1; bus_in = 8'h2F;
        tick();
        in_bus = 1'b0;
        check("ir_hold_exec", 32'(ir_q), 32'h85);

        // SUB sets carry=0, zero=1
        load_ir(8'h34);
        exec_check("sub_s2", 2'd2, c_bl, 2'd3);
        alu_carry = 1'b0; alu_zero = 1'b1;
        exec_check("sub_s3", 2'd3, c_alo | c_al | c_sub, 2'd3);
        alu_zero = 1'b0;
        load_ir(8'h85);
        exec_check("jz_z1", 2'd0, c_iro | c_pc, 2'd0);
        load_ir(8'h75);
        exec_check("jc_c0", 2'd0, c_iro, 2'd0);

        // STA, LDI, JMP, OUT, NOP
        load_ir(8'h4C);
        exec_check("sta_s0", 2'd0, c_mar, 2'd2);
        exec_check("sta_s1", 2'd1, c_iro, 2'd2);
        exec_check("sta_s2", 2'd2, c_ao | c_rw, 2'd2);
        load_ir(8'h57);
        exec_check("ldi_s0", 2'd0, c_iro | c_al, 2'd0);
        exec_check("ldi_s1", 2'd1, 11'h0, 2'd0);
        load_ir(8'h69);
        exec_check("jmp_s0", 2'd0, c_iro | c_pc, 2'd0);
        load_ir(8'hE0);
        exec_check("out_s0", 2'd0, c_ao | c_ol, 2'd0);
        exec_check("out_s3", 2'd3, 11'h0, 2'd0);
        load_ir(8'h00);
        exec_check("nop_s0", 2'd0, 11'h0, 2'd0);

        // Enables gated during fetch
        load_ir(8'h1A);
        fetch_complete = 1'b0; step = 2'd0;
        #1;
        check("fetch_gate_en", 32'(w_en), 32'h0);
        tick();

        // Illegal opcode
        load_ir(8'hB3);
        exec_check("ill_s0", 2'd0, 11'h0, 2'd0);
`ifdef ILLEGAL_TRAP_EN
        check("ill_flags", 32'({illegal_op, halted}), 32'h3);
`else
        check("ill_flags", 32'({illegal_op, halted}), 32'h0);
`endif
        reset_pulse();
        check("ill_clr", 32'({illegal_op, halted}), 32'h0);

        // Set flags, then reset mid-ADD s2
        load_ir(8'h21);
        alu_carry = 1'b1; alu_zero = 1'b1;
        exec_check("add2_s3", 2'd3, c_alo | c_al, 2'd3);
        alu_carry = 1'b0; alu_zero = 1'b0;
        fetch_complete = 1'b1; step = 2'd2;
        #1;
        check("mid_add_en", 32'(w_en), 32'(c_bl));
        rst = 1'b0;
        #1;
        check("mid_rst_en", 32'(w_en), 32'h0);
        check("mid_rst_ir", 32'(ir_q), 32'h00);
        tick();
        check("mid_rst_hold", 32'({ir_q, w_en}), 32'h0);
        rst = 1'b1;
        exec_check("post_rst_nop", 2'd0, 11'h0, 2'd0);
        load_ir(8'h75);
        exec_check("post_rst_jc", 2'd0, c_iro, 2'd0);
        load_ir(8'h85);
        exec_check("post_rst_jz", 2'd0, c_iro, 2'd0);

        // HLT
        load_ir(8'hF0);
        fetch_complete = 1'b1; step = 2'd0;
        #1;
        check("hlt_pre", 32'({halted, w_en}), 32'h0);
        tick();
        check("hlt_set", 32'(halted), 32'h1);
        load_ir(8'h50);
        check("hlt_ir_hold", 32'(ir_q), 32'hF0);
        exec_check("hlt_en0", 2'd0, 11'h0, 2'd0);
        check("hlt_sticky", 32'(halted), 32'h1);
        reset_pulse();
        check("hlt_clr", 32'(halted), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
